// File: rtl/i2c_frame_receiver.sv
// I2C write-only target that receives a fixed-length result frame, checks its header and
// byte count, and presents the decoded fields with a one-cycle valid or error strobe.
module i2c_frame_receiver #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter int unsigned FRAME_BYTES = 13,
  parameter logic [5:0]  HEADER      = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  output logic [1:0]  opcode,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] result,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned FrameBits = FRAME_BYTES * 8;
  localparam int unsigned CntW      = $clog2(FRAME_BYTES + 2);
  localparam logic [CntW-1:0] FrameCnt = CntW'(FRAME_BYTES);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAddr    = 3'd1;
  localparam logic [2:0] StAddrAck = 3'd2;
  localparam logic [2:0] StData    = 3'd3;
  localparam logic [2:0] StDataAck = 3'd4;
  localparam logic [2:0] StIgnore  = 3'd5;

  logic [1:0]           scl_sync_q, sda_sync_q;
  logic                 scl_prev_q, sda_prev_q;
  logic [2:0]           state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           byte_q, byte_d;
  logic [FrameBits-1:0] frame_q, frame_d;
  logic [CntW-1:0]      byte_cnt_q, byte_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 ack_phase_q, ack_phase_d;
  logic                 sda_low_q, sda_low_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [1:0]           opcode_q, opcode_d;
  logic [31:0]          a_q, a_d, b_q, b_d, result_q, result_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_next;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_next = {byte_q[6:0], sda_s};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_d      = byte_q;
    frame_d     = frame_q;
    byte_cnt_d  = byte_cnt_q;
    overflow_d  = overflow_q;
    ack_phase_d = ack_phase_q;
    sda_low_d   = sda_low_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    opcode_d    = opcode_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;

    if (stop_det && (state_q != StIdle)) begin
      if ((byte_cnt_q == FrameCnt) && (frame_q[FrameBits-1 -: 6] == HEADER) && !overflow_q) begin
        opcode_d = frame_q[97:96];
        a_d      = frame_q[95:64];
        b_d      = frame_q[63:32];
        result_d = frame_q[31:0];
        valid_d  = 1'b1;
      end else if (byte_cnt_q != '0) begin
        err_d = 1'b1;
      end
      state_d     = StIdle;
      bit_cnt_d   = '0;
      byte_cnt_d  = '0;
      overflow_d  = 1'b0;
      ack_phase_d = 1'b0;
      sda_low_d   = 1'b0;
      busy_d      = 1'b0;
    end else if (start_det) begin
      // Repeated START aborts whatever partial frame was in flight.
      err_d       = (state_q != StIdle) && (byte_cnt_q != '0);
      state_d     = StAddr;
      bit_cnt_d   = '0;
      byte_cnt_d  = '0;
      overflow_d  = 1'b0;
      ack_phase_d = 1'b0;
      sda_low_d   = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        StAddr: begin
          if (scl_rise) begin
            byte_d    = byte_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if ((byte_next[7:1] == SLAVE_ADDR) && !byte_next[0]) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end
        StAddrAck, StDataAck: begin
          // First falling edge starts the ACK low, the second ends the ninth clock.
          if (scl_fall) begin
            if (!ack_phase_q) begin
              ack_phase_d = 1'b1;
              sda_low_d   = 1'b1;
            end else begin
              ack_phase_d = 1'b0;
              sda_low_d   = 1'b0;
              state_d     = StData;
              bit_cnt_d   = '0;
            end
          end
        end
        StData: begin
          if (scl_rise) begin
            byte_d    = byte_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              frame_d    = {frame_q[FrameBits-9:0], byte_next};
              byte_cnt_d = byte_cnt_q + 1'b1;
              if (byte_cnt_q < FrameCnt) begin
                state_d = StDataAck;
              end else begin
                overflow_d = 1'b1;
                state_d    = StIgnore;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      byte_q      <= '0;
      frame_q     <= '0;
      byte_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      ack_phase_q <= 1'b0;
      sda_low_q   <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      opcode_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
    end else begin
      scl_sync_q  <= {scl_sync_q[0], i2c_scl};
      sda_sync_q  <= {sda_sync_q[0], i2c_sda};
      scl_prev_q  <= scl_sync_q[1];
      sda_prev_q  <= sda_sync_q[1];
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_q      <= byte_d;
      frame_q     <= frame_d;
      byte_cnt_q  <= byte_cnt_d;
      overflow_q  <= overflow_d;
      ack_phase_q <= ack_phase_d;
      sda_low_q   <= sda_low_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      opcode_q    <= opcode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
    end
  end

  assign i2c_sda     = sda_low_q ? 1'b0 : 1'bz;
  assign opcode      = opcode_q;
  assign a           = a_q;
  assign b           = b_q;
  assign result      = result_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign busy        = busy_q;

endmodule
